// File: rtl/clkgen_pkg.sv
// Shared types and constants for the DCM_CLKGEN run-time programming controller.
// Holds the controller state encoding and the serial command frame layout.
package clkgen_pkg;

  typedef enum logic [3:0] {
    DCM_RESET,
    WAIT_LOCK,
    IDLE,
    LOAD_D,
    GAP_D,
    LOAD_M,
    GAP_M,
    GO,
    WAIT_DONE
  } state_t;

  // Command prefixes are written {second bit, first bit}; bit 0 goes out first.
  localparam logic [1:0] CMD_LOAD_D = 2'b01;
  localparam logic [1:0] CMD_LOAD_M = 2'b11;
  localparam int         LOAD_LEN   = 10;

  // Serial frame, LSB transmitted first: two command bits then the 8-bit value.
  function automatic logic [LOAD_LEN-1:0] prog_frame(input logic [1:0] cmd,
                                                     input logic [7:0] val);
    return {val, cmd};
  endfunction

endpackage

// File: rtl/dcm_prog_ctrl_if.sv
// Bundle of host request, status and DCM-facing signals for dcm_prog_ctrl.
// The controller uses the slave view; the host/DCM side uses the master view.
interface dcm_prog_ctrl_if;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_m_m1;
  logic [7:0] cfg_d_m1;
  logic       dcm_locked;
  logic       dcm_progdone;
  logic       prog_en;
  logic       prog_data;
  logic       dcm_rst;
  logic       busy;
  logic       locked;
  logic [7:0] cur_m_m1;
  logic [7:0] cur_d_m1;
  logic       cfg_err;
  logic [7:0] relock_cnt;

  modport slave (
    input  cfg_valid, cfg_m_m1, cfg_d_m1, dcm_locked, dcm_progdone,
    output cfg_ready, prog_en, prog_data, dcm_rst, busy, locked,
           cur_m_m1, cur_d_m1, cfg_err, relock_cnt
  );

  modport master (
    output cfg_valid, cfg_m_m1, cfg_d_m1, dcm_locked, dcm_progdone,
    input  cfg_ready, prog_en, prog_data, dcm_rst, busy, locked,
           cur_m_m1, cur_d_m1, cfg_err, relock_cnt
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level; two cycles of latency.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Programs DCM_CLKGEN M/D over PROGEN/PROGDATA and supervises LOCKED with reset/relock.
// Outputs are registered from the next state; a request is taken only while cfg_ready.
module dcm_prog_ctrl
  import clkgen_pkg::*;
#(
  parameter logic [7:0] M_DEFAULT_M1 = 8'd1,
  parameter logic [7:0] D_DEFAULT_M1 = 8'd0,
  parameter int         RST_CYCLES   = 4,
  parameter int         DONE_TIMEOUT = 1024,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter int         LOSS_FILTER  = 8
) (
  input  logic          clk,
  input  logic          rst,
  dcm_prog_ctrl_if.slave bus
);

  localparam int CNT_MAX = (LOCK_TIMEOUT > DONE_TIMEOUT) ? LOCK_TIMEOUT : DONE_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LOSS_W  = $clog2(LOSS_FILTER + 1);
  localparam int BIT_W   = $clog2(LOAD_LEN);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [LOSS_W-1:0]   r_loss_cnt;
  logic [7:0]          r_shadow_m;
  logic [7:0]          r_shadow_d;

  logic                r_prog_en;
  logic                r_prog_data;
  logic                r_dcm_rst;
  logic                r_busy;
  logic                r_cfg_ready;
  logic                r_locked;
  logic [7:0]          r_cur_m;
  logic [7:0]          r_cur_d;
  logic                r_cfg_err;
  logic [7:0]          r_relock_cnt;

  logic                w_locked_sync;
  logic                w_progdone_sync;
  logic                w_accept;
  logic                w_loss;
  logic                w_done;
  logic                w_relock_inc;
  logic                w_err_nxt;
  logic                w_en_nxt;
  logic                w_data_nxt;
  logic                w_locked_nxt;
  logic [LOAD_LEN-1:0] w_frame_d;
  logic [LOAD_LEN-1:0] w_frame_m;

  sync2 u_sync_locked (
    .clk (clk),
    .rst (rst),
    .i_d (bus.dcm_locked),
    .o_q (w_locked_sync)
  );

  sync2 u_sync_progdone (
    .clk (clk),
    .rst (rst),
    .i_d (bus.dcm_progdone),
    .o_q (w_progdone_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= DCM_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_loss       = 1'b0;
    w_done       = 1'b0;
    w_relock_inc = 1'b0;
    w_err_nxt    = 1'b0;
    case (r_state)
      DCM_RESET: begin
        if (r_cnt == CNT_W'(RST_CYCLES - 1)) w_state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_locked_sync) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
          w_state_nxt  = DCM_RESET;
          w_relock_inc = 1'b1;
        end
      end
      IDLE: begin
        // Lock loss outranks a simultaneous request, which is then dropped.
        if (!w_locked_sync && (r_loss_cnt == LOSS_W'(LOSS_FILTER - 1))) begin
          w_loss       = 1'b1;
          w_relock_inc = 1'b1;
          w_state_nxt  = DCM_RESET;
        end else if (bus.cfg_valid && r_cfg_ready) begin
          if (bus.cfg_m_m1 == 8'd0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = LOAD_D;
          end
        end
      end
      LOAD_D: begin
        if (r_cnt == CNT_W'(LOAD_LEN - 1)) w_state_nxt = GAP_D;
      end
      GAP_D:  w_state_nxt = LOAD_M;
      LOAD_M: begin
        if (r_cnt == CNT_W'(LOAD_LEN - 1)) w_state_nxt = GAP_M;
      end
      GAP_M:  w_state_nxt = GO;
      GO:     w_state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        if (w_progdone_sync) begin
          w_done      = 1'b1;
          w_state_nxt = WAIT_LOCK;
        end else if (r_cnt == CNT_W'(DONE_TIMEOUT - 1)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = DCM_RESET;
        end
      end
      default: w_state_nxt = DCM_RESET;
    endcase
  end

  // Outputs are precomputed for the state being entered so they line up with it.
  always_comb begin
    w_cnt_nxt    = '0;
    w_en_nxt     = 1'b0;
    w_data_nxt   = 1'b0;
    w_locked_nxt = 1'b0;
    w_frame_d    = prog_frame(CMD_LOAD_D, w_accept ? bus.cfg_d_m1 : r_shadow_d);
    w_frame_m    = prog_frame(CMD_LOAD_M, r_shadow_m);
    if ((w_state_nxt == r_state) && (r_state != IDLE)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
    case (w_state_nxt)
      LOAD_D: begin
        w_en_nxt   = 1'b1;
        w_data_nxt = w_frame_d[w_cnt_nxt[BIT_W-1:0]];
      end
      LOAD_M: begin
        w_en_nxt   = 1'b1;
        w_data_nxt = w_frame_m[w_cnt_nxt[BIT_W-1:0]];
      end
      GO: begin
        w_en_nxt   = 1'b1;
        w_data_nxt = 1'b0;
      end
      default: begin
        w_en_nxt   = 1'b0;
        w_data_nxt = 1'b0;
      end
    endcase
    // The filtered lock is held through programming and only dropped once GO is issued.
    w_locked_nxt = w_state_nxt inside {IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_loss_cnt   <= '0;
      r_shadow_m   <= M_DEFAULT_M1;
      r_shadow_d   <= D_DEFAULT_M1;
      r_prog_en    <= 1'b0;
      r_prog_data  <= 1'b0;
      r_dcm_rst    <= 1'b1;
      r_busy       <= 1'b1;
      r_cfg_ready  <= 1'b0;
      r_locked     <= 1'b0;
      r_cur_m      <= M_DEFAULT_M1;
      r_cur_d      <= D_DEFAULT_M1;
      r_cfg_err    <= 1'b0;
      r_relock_cnt <= 8'd0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if ((r_state == IDLE) && !w_loss && !w_accept && !w_locked_sync) begin
        r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
      end else begin
        r_loss_cnt <= '0;
      end
      if (w_accept) begin
        r_shadow_m <= bus.cfg_m_m1;
        r_shadow_d <= bus.cfg_d_m1;
      end
      r_prog_en   <= w_en_nxt;
      r_prog_data <= w_data_nxt;
      r_dcm_rst   <= (w_state_nxt == DCM_RESET);
      r_busy      <= (w_state_nxt != IDLE);
      r_cfg_ready <= (w_state_nxt == IDLE);
      r_locked    <= w_locked_nxt;
      r_cfg_err   <= w_err_nxt;
      // A DCM reset reloads its power-on attributes, so the reported M/D follow.
      if (w_state_nxt == DCM_RESET) begin
        r_cur_m <= M_DEFAULT_M1;
        r_cur_d <= D_DEFAULT_M1;
      end else if (w_done) begin
        r_cur_m <= r_shadow_m;
        r_cur_d <= r_shadow_d;
      end
      if (w_relock_inc && (r_relock_cnt != 8'hFF)) begin
        r_relock_cnt <= r_relock_cnt + 8'd1;
      end
    end
  end

  assign bus.prog_en    = r_prog_en;
  assign bus.prog_data  = r_prog_data;
  assign bus.dcm_rst    = r_dcm_rst;
  assign bus.busy       = r_busy;
  assign bus.cfg_ready  = r_cfg_ready;
  assign bus.locked     = r_locked;
  assign bus.cur_m_m1   = r_cur_m;
  assign bus.cur_d_m1   = r_cur_d;
  assign bus.cfg_err    = r_cfg_err;
  assign bus.relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench for dcm_prog_ctrl with a behavioural DCM and a serial-bit scoreboard.
module tb_dcm_prog_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int DONE_TIMEOUT = 1024;
  localparam int LOCK_DLY     = 100;
  localparam int DONE_DLY     = 20;
  localparam int IDLE_CTR     = 1 << 20;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int   total = 0;
  int   bad   = 0;
  int   pe_seen;
  logic exp_q[$];

  int   m_lock_ctr = 0;
  int   m_done_ctr = IDLE_CTR;
  bit   m_drop     = 1'b0;
  bit   m_no_done  = 1'b0;
  logic m_prev_en  = 1'b0;

  dcm_prog_ctrl_if ifc ();

  dcm_prog_ctrl #(
    .M_DEFAULT_M1 (8'd1),
    .D_DEFAULT_M1 (8'd0),
    .RST_CYCLES   (RST_CYCLES),
    .DONE_TIMEOUT (DONE_TIMEOUT),
    .LOCK_TIMEOUT (65535),
    .LOSS_FILTER  (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // DCM model: locks LOCK_DLY cycles after reset release or GO, PROGDONE DONE_DLY after GO.
  always @(negedge clk) begin
    if (ifc.prog_en && !m_prev_en && !ifc.prog_data) begin
      m_lock_ctr = 0;
      m_done_ctr = 0;
    end
    m_prev_en = ifc.prog_en;
    if (m_done_ctr < IDLE_CTR) m_done_ctr++;
    if (ifc.dcm_rst) m_lock_ctr = 0;
    else if (m_lock_ctr < LOCK_DLY) m_lock_ctr++;
    ifc.dcm_locked   = !m_drop && !ifc.dcm_rst && (m_lock_ctr >= LOCK_DLY);
    ifc.dcm_progdone = !m_no_done && (m_done_ctr >= DONE_DLY) && (m_done_ctr < DONE_DLY + 2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_locked(input string tag, input int budget);
    int n;
    n = 0;
    while (ifc.locked !== 1'b1 && n < budget) begin
      tick();
      n++;
      if (ifc.prog_en) pe_seen++;
    end
    check(tag, 32'(ifc.locked), 32'd1);
  endtask

  task automatic rst_width(input string tag);
    int n;
    n = 0;
    while (ifc.dcm_rst && n < 50) begin
      tick();
      n++;
    end
    check(tag, n, RST_CYCLES);
  endtask

  // Pushes the expected PROGDATA stream, issues the request and checks it bit by bit.
  task automatic do_request(input logic [7:0] m, input logic [7:0] d, input int abort_at);
    logic [9:0] fd;
    logic [9:0] fm;
    logic       b;
    fd = {d, 1'b0, 1'b1};
    fm = {m, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) exp_q.push_back(fd[i]);
    for (int i = 0; i < 10; i++) exp_q.push_back(fm[i]);
    exp_q.push_back(1'b0);
    ifc.cfg_m_m1  = m;
    ifc.cfg_d_m1  = d;
    ifc.cfg_valid = 1'b1;
    tick();
    ifc.cfg_valid = 1'b0;
    check("ready_fall", 32'(ifc.cfg_ready), 32'd0);
    for (int c = 0; c <= 22; c++) begin
      if (c == 10 || c == 21) begin
        check($sformatf("gap_en[%0d]", c), 32'(ifc.prog_en), 32'd0);
      end else begin
        check($sformatf("load_en[%0d]", c), 32'(ifc.prog_en), 32'd1);
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          b = exp_q.pop_front();
          check($sformatf("prog_data[%0d]", c), 32'(ifc.prog_data), 32'(b));
        end
      end
      if (c == 22) check("go_locked", 32'(ifc.locked), 32'd1);
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check("abort_prog_en", 32'(ifc.prog_en), 32'd0);
        check("abort_dcm_rst", 32'(ifc.dcm_rst), 32'd1);
        check("abort_cur_m", 32'(ifc.cur_m_m1), 32'd1);
        exp_q.delete();
        return;
      end
      if (c < 22) tick();
    end
    tick();
    check("go_width", 32'(ifc.prog_en), 32'd0);
    check("wait_done_locked", 32'(ifc.locked), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_m_m1  = 8'd0;
    ifc.cfg_d_m1  = 8'd0;
    pe_seen       = 0;

    // Power-on
    repeat (5) tick();
    check("rst_prog_en", 32'(ifc.prog_en), 32'd0);
    check("rst_prog_data", 32'(ifc.prog_data), 32'd0);
    check("rst_dcm_rst", 32'(ifc.dcm_rst), 32'd1);
    check("rst_busy", 32'(ifc.busy), 32'd1);
    check("rst_cfg_ready", 32'(ifc.cfg_ready), 32'd0);
    check("rst_locked", 32'(ifc.locked), 32'd0);
    check("rst_cur_m", 32'(ifc.cur_m_m1), 32'd1);
    check("rst_cur_d", 32'(ifc.cur_d_m1), 32'd0);
    check("rst_cfg_err", 32'(ifc.cfg_err), 32'd0);
    check("rst_relock", 32'(ifc.relock_cnt), 32'd0);
    rst = 1'b0;
    rst_width("por_rst_width");
    wait_locked("por_lock", 400);
    check("por_ready", 32'(ifc.cfg_ready), 32'd1);
    check("por_busy", 32'(ifc.busy), 32'd0);
    check("por_cur_m", 32'(ifc.cur_m_m1), 32'd1);
    check("por_cur_d", 32'(ifc.cur_d_m1), 32'd0);

    // Program M=5, D=2
    do_request(8'd4, 8'd1, -1);
    check("cur_before_done", 32'(ifc.cur_m_m1), 32'd1);
    wait_locked("prog1_lock", 400);
    check("prog1_cur_m", 32'(ifc.cur_m_m1), 32'd4);
    check("prog1_cur_d", 32'(ifc.cur_d_m1), 32'd1);
    check("prog1_busy", 32'(ifc.busy), 32'd0);

    // Illegal request
    ifc.cfg_m_m1  = 8'd0;
    ifc.cfg_d_m1  = 8'd5;
    ifc.cfg_valid = 1'b1;
    tick();
    ifc.cfg_valid = 1'b0;
    check("illegal_err", 32'(ifc.cfg_err), 32'd1);
    check("illegal_ready", 32'(ifc.cfg_ready), 32'd1);
    check("illegal_busy", 32'(ifc.busy), 32'd0);
    check("illegal_prog_en", 32'(ifc.prog_en), 32'd0);
    tick();
    check("illegal_err_pulse", 32'(ifc.cfg_err), 32'd0);
    repeat (3) tick();
    check("illegal_prog_en_late", 32'(ifc.prog_en), 32'd0);
    check("illegal_cur_m", 32'(ifc.cur_m_m1), 32'd4);

    // PROGDONE timeout
    m_no_done = 1'b1;
    do_request(8'd6, 8'd2, -1);
    n = 0;
    while (!ifc.cfg_err && n < 2 * DONE_TIMEOUT) begin
      tick();
      n++;
    end
    check("done_timeout_cycles", n, DONE_TIMEOUT);
    check("timeout_dcm_rst", 32'(ifc.dcm_rst), 32'd1);
    check("timeout_cur_m", 32'(ifc.cur_m_m1), 32'd1);
    check("timeout_cur_d", 32'(ifc.cur_d_m1), 32'd0);
    tick();
    check("timeout_err_pulse", 32'(ifc.cfg_err), 32'd0);
    check("timeout_relock", 32'(ifc.relock_cnt), 32'd0);
    m_no_done = 1'b0;
    wait_locked("timeout_relock_lock", 400);

    // Short lock drop is filtered out
    m_drop = 1'b1;
    repeat (5) tick();
    m_drop = 1'b0;
    repeat (10) tick();
    check("short_drop_locked", 32'(ifc.locked), 32'd1);
    check("short_drop_relock", 32'(ifc.relock_cnt), 32'd0);
    check("short_drop_dcm_rst", 32'(ifc.dcm_rst), 32'd0);

    // Long lock drop with a request landing in the loss cycle
    m_drop = 1'b1;
    repeat (9) tick();
    check("loss_not_yet", 32'(ifc.dcm_rst), 32'd0);
    ifc.cfg_m_m1  = 8'd3;
    ifc.cfg_d_m1  = 8'd3;
    ifc.cfg_valid = 1'b1;
    tick();
    ifc.cfg_valid = 1'b0;
    m_drop        = 1'b0;
    check("loss_dcm_rst", 32'(ifc.dcm_rst), 32'd1);
    check("loss_locked", 32'(ifc.locked), 32'd0);
    check("loss_relock", 32'(ifc.relock_cnt), 32'd1);
    check("loss_prog_en", 32'(ifc.prog_en), 32'd0);
    rst_width("loss_rst_width");
    pe_seen = 0;
    wait_locked("loss_relock_lock", 400);
    check("loss_req_dropped", pe_seen, 0);
    check("loss_cur_m", 32'(ifc.cur_m_m1), 32'd1);

    // Extreme legal values
    do_request(8'hFF, 8'h00, -1);
    wait_locked("prog2_lock", 400);
    check("prog2_cur_m", 32'(ifc.cur_m_m1), 32'd255);
    check("prog2_cur_d", 32'(ifc.cur_d_m1), 32'd0);

    // Reset at bit 5 of LOAD_M
    do_request(8'd20, 8'd7, 16);
    repeat (3) tick();
    rst = 1'b0;
    rst_width("abort_rst_width");
    wait_locked("abort_lock", 400);
    check("abort_cur_m_after", 32'(ifc.cur_m_m1), 32'd1);
    check("abort_cur_d_after", 32'(ifc.cur_d_m1), 32'd0);
    check("abort_relock", 32'(ifc.relock_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcm_prog_ctrl.md
Name: dcm_prog_ctrl

Overview:
- Run-time controller for the Spartan-6 DCM_CLKGEN that produces the mining core clock.
- Serially programs new multiply/divide (M/D) values through the PROG interface.
- Supervises LOCKED, and resets and relocks the DCM when lock is lost.
- Sits beside the clock generator and is driven by the host-side register block. Its clock is also wired to the DCM's PROGCLK.

Parameters:
- M_DEFAULT_M1, 1, power-on M-1 (M=2).
- D_DEFAULT_M1, 0, power-on D-1 (D=1).
- RST_CYCLES, 4, dcm_rst pulse width in clk cycles. Minimum 3.
- DONE_TIMEOUT, 1024, max cycles from GO to PROGDONE.
- LOCK_TIMEOUT, 65535, max cycles waiting for LOCKED after reset or program.
- LOSS_FILTER, 8, consecutive unlocked cycles in IDLE that count as lock loss.

Ports:
- clk  in  1  controller clock; also drives DCM PROGCLK
- rst  in  1  asynchronous active-high reset
- cfg_valid  in  1  new M/D request
- cfg_ready  out  1  high only in IDLE
- cfg_m_m1  in  8  requested M-1; legal range 1..255
- cfg_d_m1  in  8  requested D-1; legal range 0..255
- dcm_locked  in  1  DCM LOCKED (asynchronous)
- dcm_progdone  in  1  DCM PROGDONE (asynchronous)
- prog_en  out  1  to DCM PROGEN
- prog_data  out  1  to DCM PROGDATA
- dcm_rst  out  1  to DCM RST
- busy  out  1  state is not IDLE
- locked  out  1  synchronised and filtered lock indication
- cur_m_m1  out  8  M-1 currently in effect
- cur_d_m1  out  8  D-1 currently in effect
- cfg_err  out  1  one-cycle pulse: illegal request or PROGDONE timeout
- relock_cnt  out  8  saturating count of lock-loss and lock-timeout recoveries

Behaviour:
- **Synchronisers.** dcm_locked and dcm_progdone each pass through a 2-flop synchroniser; all logic uses the synchronised copies.
- **Output registers.** Every output is registered. prog_en and prog_data change on the clk rising edge, and the DCM samples them on the next PROGCLK rising edge.
- **Reset values.**
  - prog_en=0, prog_data=0, dcm_rst=1, busy=1, cfg_ready=0, locked=0.
  - cur_m_m1=M_DEFAULT_M1, cur_d_m1=D_DEFAULT_M1, cfg_err=0, relock_cnt=0.
  - The state machine enters DCM_RESET on rst release.
- **State machine** (states: DCM_RESET, WAIT_LOCK, IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT_DONE):
  - DCM_RESET: dcm_rst=1 for RST_CYCLES cycles. cur_* revert to their defaults, because the DCM reloads its attributes on reset. Next: WAIT_LOCK.
  - WAIT_LOCK: counts cycles.
    - locked_sync=1 → IDLE and locked=1.
    - Counter reaches LOCK_TIMEOUT → relock_cnt++ and back to DCM_RESET.
  - IDLE: cfg_ready=1. A transfer happens when cfg_valid && cfg_ready.
    - If cfg_m_m1==0: cfg_err pulses for 1 cycle and the state stays IDLE.
    - Otherwise latch the request into shadow registers and go to LOAD_D.
    - If the lock-loss filter fires (LOSS_FILTER consecutive cycles with locked_sync=0): locked=0, relock_cnt++, go to DCM_RESET.
    - If loss and cfg_valid occur in the same cycle, loss wins and the request is not accepted.
  - LOAD_D: 10 cycles with prog_en=1. prog_data sequence is 1, 0, then shadow D-1 LSB first.
  - GAP_D: 1 cycle with prog_en=0, prog_data=0.
  - LOAD_M: 10 cycles with prog_en=1. prog_data sequence is 1, 1, then shadow M-1 LSB first.
  - GAP_M: 1 cycle idle.
  - GO: 1 cycle with prog_en=1, prog_data=0. Then WAIT_DONE, with locked=0.
  - WAIT_DONE:
    - progdone_sync=1 → cur_* take the shadow values, go to WAIT_LOCK.
    - DONE_TIMEOUT elapses → cfg_err pulse, go to DCM_RESET.
- **Timing.**
  - Request acceptance to GO asserted: 22 cycles.
  - cfg_ready falls the cycle after acceptance.
- **Lock supervision.** Lock loss is only evaluated in IDLE; lock is expected to drop while programming.
- **Counters.** relock_cnt saturates at 255.
- **Reset mid-operation.** Asserting rst in any state immediately forces the reset values. Any partial serial load is abandoned, and the DCM is reset on release.

Decomposition:
- Package clkgen_pkg holds:
  - the state enum;
  - command prefix constants CMD_LOAD_D=2'b01 and CMD_LOAD_M=2'b11, written as {second bit, first bit};
  - LOAD_LEN=10.
- One sub-module, sync2: a generic 2-flop synchroniser, instantiated twice.

Test Plan:
- **Power-on.** rst for 5 cycles, model locks 100 cycles after dcm_rst falls → dcm_rst high 4 cycles after release; locked=1, cur_m_m1=1, cur_d_m1=0, cfg_ready=1.
- **Program M=5, D=2** (cfg_m_m1=4, cfg_d_m1=1):
  - prog_data during LOAD_D = 1,0,1,0,0,0,0,0,0,0.
  - prog_data during LOAD_M = 1,1,0,0,1,0,0,0,0,0.
  - GO on cycle 22 after acceptance.
  - PROGDONE then lock → cur_m_m1=4, cur_d_m1=1.
- **Illegal request.** cfg_m_m1=0 in IDLE → cfg_err for one cycle; prog_en stays 0; state stays IDLE.
- **PROGDONE timeout.** Model never raises PROGDONE → cfg_err after 1024 cycles in WAIT_DONE, dcm_rst asserted, cur_* return to defaults.
- **Lock loss.**
  - dcm_locked drops for 5 cycles in IDLE → no action.
  - dcm_locked drops for 10 cycles → locked=0, relock_cnt=1, dcm_rst pulse.
  - cfg_valid in the loss cycle is not accepted.
- **Reset mid-LOAD_M.** Assert rst at bit 5 of LOAD_M → prog_en=0 immediately; after release a full DCM reset and relock occur; cur_* remain at defaults.
